// File: rtl/seg_scan_pkg.sv
// Shared widths and helpers for the 7-segment scan controller.
// Up to eight BCD digits are supported; indices are always IDX_W bits wide.
package seg_scan_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam int MAX_DIGITS = 8;
    localparam int IDX_W = 3;
    localparam int PACK_W = BCD_W * MAX_DIGITS;

    // Digit k of a packed vector, digit 0 in the least significant nibble.
    function automatic logic [BCD_W-1:0] getDigit(input logic [PACK_W-1:0] vec,
                                                  input logic [IDX_W-1:0] k);
        return vec[{k, 2'b00} +: BCD_W];
    endfunction

endpackage

// File: rtl/seg_tick_div.sv
// Generic modulo-N counter with a terminal-count flag, used for both the
// digit-slot prescaler and the blink half-period timer.
module seg_tick_div #(
    parameter int N = 4,
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i || tc_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a shared BCD-to-7-segment decoder.
// Optional leading-zero suppression is built when LZ_SUPPRESS_EN is defined.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 2,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    set_mode_i,
    input  logic [2:0]              set_sel_i,
    output logic [BCD_W-1:0]        bcd_o,
    output logic                    en_o,
    output logic                    blank_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int PRES_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PRES_W-1:0]       pres;
    logic                    presTc;
    logic [BLINK_W-1:0]      blinkCnt_unused;
    logic                    blinkTc;

    logic                    enPrev_q;
    logic                    frame_q;
    logic                    blinkPhase_q;
    logic [IDX_W-1:0]        idx_q;
    logic [4*NUM_DIGITS-1:0] shadow_q;
    logic [BCD_W-1:0]        bcd_q;
    logic                    en_q;
    logic                    blank_q;
    logic [NUM_DIGITS-1:0]   an_q;

    logic                    start;
    logic                    tick;
    logic                    wrap;
    logic                    snap;
    logic                    active;
    logic                    selHit;
    logic                    lzBlank;
    logic [PACK_W-1:0]       shadowWide;
    logic [BCD_W-1:0]        curDigit;
    logic                    blank_d;
    logic [NUM_DIGITS-1:0]   an_d;

    // A fresh enable restarts the slot sequence just like a frame wrap does.
    assign start  = en_i && !enPrev_q;
    assign tick   = presTc && en_i && !start;
    assign wrap   = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign snap   = start || wrap;
    assign active = en_i && enPrev_q;

    seg_tick_div #(.N(SCAN_DIV)) u_slot_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (!en_i || start),
        .cnt_o (pres),
        .tc_o  (presTc)
    );

    seg_tick_div #(.N(BLINK_DIV)) u_blink_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .cnt_o (blinkCnt_unused),
        .tc_o  (blinkTc)
    );

    always_comb begin
        shadowWide = '0;
        shadowWide[4*NUM_DIGITS-1:0] = shadow_q;
    end

    assign curDigit = getDigit(shadowWide, idx_q);
    assign selHit   = set_mode_i && (set_sel_i == idx_q);

`ifdef LZ_SUPPRESS_EN
    logic [MAX_DIGITS-1:0] lzMask;

    // Walk down from the most significant digit while everything seen is zero.
    always_comb begin
        logic allZero;
        lzMask  = '0;
        allZero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            allZero   = allZero && (getDigit(shadowWide, IDX_W'(k)) == '0);
            lzMask[k] = allZero;
        end
    end

    assign lzBlank = lzMask[idx_q] && !selHit;
`else
    assign lzBlank = 1'b0;
`endif

    assign blank_d = (curDigit > BCD_MAX) || (selHit && blinkPhase_q) || lzBlank;

    always_comb begin
        an_d = '1;
        if (pres >= PRES_W'(GUARD)) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    an_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enPrev_q     <= 1'b0;
            frame_q      <= 1'b0;
            blinkPhase_q <= 1'b0;
            idx_q        <= '0;
            shadow_q     <= '0;
            bcd_q        <= '0;
            en_q         <= 1'b0;
            blank_q      <= 1'b1;
            an_q         <= '1;
        end else begin
            enPrev_q <= en_i;
            frame_q  <= snap;
            if (snap) begin
                shadow_q <= digits_i;
            end
            if (!en_i || start || wrap) begin
                idx_q <= '0;
            end else if (tick) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (blinkTc) begin
                blinkPhase_q <= ~blinkPhase_q;
            end
            bcd_q   <= active ? curDigit : '0;
            en_q    <= active;
            blank_q <= active ? blank_d : 1'b1;
            an_q    <= active ? an_d : '1;
        end
    end

    assign bcd_o   = bcd_q;
    assign en_o    = en_q;
    assign blank_o = blank_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a shared BCD-to-7-segment decoder. It walks NUM_DIGITS digit positions at a fixed slot rate. For each position it presents that digit's BCD code, the decoder enable and the blank request to the single decoder, and drives the matching active-low digit-select line. It sits between the clock/counter datapath, which supplies packed BCD digits, and the display pins. It also provides frame-coherent sampling, anti-ghosting guard time and set-mode blinking of one selected digit.

## Interface
- NUM_DIGITS, 6: number of multiplexed digit positions (2..8).
- SCAN_DIV, 50000: clock cycles per digit slot (≥ GUARD+2).
- GUARD, 2: cycles at the start of each slot with all digit selects off (≥ 1).
- BLINK_DIV, 12500000: clock cycles per blink half-period.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_i  in  1  display enable.
- digits_i  in  4*NUM_DIGITS  packed BCD; digit k at bits [4k+3:4k]; digit 0 is rightmost/least significant.
- set_mode_i  in  1  set mode active.
- set_sel_i  in  3  index of the digit being set.
- bcd_o  out  4  BCD code to the decoder.
- en_o  out  1  decoder enable (1 = decode).
- blank_o  out  1  decoder blank request (1 = all segments off).
- an_o  out  NUM_DIGITS  digit selects, active-low, at most one low.
- frame_o  out  1  one-cycle pulse when a new frame snapshot is taken.

## Operation
- Prescaler `pres` counts 0..SCAN_DIV-1; `tick` = (pres == SCAN_DIV-1). Slot index `idx` advances on tick and wraps from NUM_DIGITS-1 to 0.
- Snapshot:
  - On the tick that wraps idx to 0, the `shadow` register loads digits_i and frame_o pulses.
  - On the first cycle with en_i high after reset or after en_i was low, shadow also loads and frame_o pulses.
  - digits_i is never displayed directly.
- While en_i = 0: pres = 0, idx = 0, an_o all ones, en_o = 0, blank_o = 1. The blink generator keeps running.
- Per slot, with en_i = 1:
  - bcd_o = shadow[idx].
  - en_o = 1.
  - an_o[idx] = 0 when pres ≥ GUARD; otherwise an_o is all ones.
- blank_o = 1 when any of these holds:
  - shadow[idx] > 9.
  - set_mode_i = 1, idx == set_sel_i and blink_phase = 1.
  - Leading-zero suppression applies (see Configuration).
- Blink generator: counter 0..BLINK_DIV-1. blink_phase toggles at terminal count and resets to 0. set_sel_i ≥ NUM_DIGITS means no digit blinks.
- A set_mode_i or set_sel_i change takes effect on the next output update. It does not wait for the frame boundary.

## Timing
- All outputs are registered: outputs in cycle n+1 reflect internal state and inputs in cycle n.
- Reset values: bcd_o = 0, en_o = 0, blank_o = 1, an_o all ones, frame_o = 0, pres = 0, idx = 0, shadow = 0, blink_phase = 0.
- Slot length is exactly SCAN_DIV cycles. Frame length is NUM_DIGITS*SCAN_DIV cycles.
- digits_i sampled on the frame tick appears at the start of slot 0, one cycle after frame_o.
- An input change mid-frame becomes visible at the next frame only, so no torn frames.
- Asynchronous reset mid-slot: outputs reach their reset values immediately. Scanning restarts at slot 0 with a fresh snapshot once en_i is seen high.
- en_i falling mid-slot: one cycle later an_o is all ones.

## Configuration
- LZ_SUPPRESS_EN defined:
  - Digit k > 0 is blanked when shadow digits k..NUM_DIGITS-1 are all 0.
  - Digit 0 is never suppressed.
  - A digit equal to set_sel_i is never suppressed while set_mode_i = 1.
- LZ_SUPPRESS_EN undefined: zeros display normally, and no suppression logic is built.

## Structure
- Package seg_scan_pkg holds:
  - BCD_W = 4 and BCD_MAX = 9.
  - IDX_W, sized for 8 digits.
  - The function that extracts digit k from a packed vector.
- One sub-module, seg_tick_div: a generic modulo-N counter with terminal-count pulse. It is instantiated twice, once for the slot prescaler (SCAN_DIV) and once for the blink generator (BLINK_DIV).
- Snapshot, slot sequencing, guard and blank logic live in seg_scan_ctrl.

## Test plan
Bench parameters: NUM_DIGITS = 4, SCAN_DIV = 4, GUARD = 1, BLINK_DIV = 32.
- Hold rst_n low -> an_o = 4'b1111, blank_o = 1, en_o = 0, bcd_o = 0, frame_o = 0.
- digits_i = 16'h1234, en_i = 1 -> bcd_o sequence 4, 3, 2, 1, each for 4 cycles. an_o is 1111 for the first cycle of each slot, then 1110, 1101, 1011, 0111. frame_o pulses once every 16 cycles.
- Switch digits_i to 16'h5678 during slot 1 -> the rest of that frame shows 3, 2, 1. The next frame shows 8, 7, 6, 5.
- set_mode_i = 1, set_sel_i = 2, digits 16'h1234 -> blank_o toggles every 32 cycles in slot 2 only. With set_sel_i = 5, blank_o stays 0.
- digits_i = 16'h0A05 -> blank_o = 1 during slot 2 (code 0xA).
- digits_i = 16'h0045:
  - With LZ_SUPPRESS_EN, slots 2 and 3 are blanked.
  - With LZ_SUPPRESS_EN and set_mode_i = 1, set_sel_i = 3, slot 3 is not suppressed; it is blanked only during blink_phase = 1.
  - Without LZ_SUPPRESS_EN, no slot is blanked.
  - Assert rst_n low mid-slot 2: all outputs reach reset values without waiting for a clock edge.
